// File: rtl/mf_peak_search.sv
// ---------------------------------------------------------------------------
// mf_peak_search
//
// Searches a window of matched-filter power samples (I^2+Q^2) for the largest
// value and reports it with its 0-based position in the window. A search is
// armed by a one-cycle start pulse. Only cycles with sum_vld=1 count as
// samples. On completion, done pulses for one cycle. peak_val, peak_idx and
// found are updated on that same cycle and hold until the next done or reset.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst        : asynchronous, active-high reset
//   start      : one-cycle pulse arming a search (ignored unless idle)
//   win_len    : samples per search, latched on accepted start
//   threshold  : unsigned detection threshold, latched on accepted start
//   sum        : unsigned power sample
//   sum_vld    : qualifies sum for the current cycle (used only in SEARCH)
//   busy       : high while a search is in progress
//   done       : one-cycle completion pulse
//   found      : peak_val >= latched threshold, valid from done
//   peak_val   : maximum sample of the last completed window
//   peak_idx   : index of the first occurrence of peak_val
//   state_dbg  : current FSM state (0=IDLE, 1=SEARCH, 2=REPORT)
//
// Handshake: start is accepted only on a clock edge where the FSM is IDLE.
// A sample is consumed on every clock edge in SEARCH with sum_vld=1.
// There is no backpressure.
// ---------------------------------------------------------------------------
module mf_peak_search #(
  parameter int SUM_W = 24,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [SUM_W-1:0] threshold,
  input  logic [SUM_W-1:0] sum,
  input  logic             sum_vld,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [SUM_W-1:0] peak_val,
  output logic [WIN_W-1:0] peak_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIN_W-1:0] len_q;
  logic [SUM_W-1:0] thr_q;
  logic [WIN_W-1:0] cnt_q;
  logic [SUM_W-1:0] max_q;
  logic [WIN_W-1:0] idx_q;

  // Running maximum including the sample presented this cycle. The first
  // sample always loads. Later samples load only on a strict increase, so a
  // tie keeps the earliest index.
  logic             take;
  logic [SUM_W-1:0] max_nxt;
  logic [WIN_W-1:0] idx_nxt;
  logic             last;

  always_comb begin
    take    = (cnt_q == '0) || (sum > max_q);
    max_nxt = take ? sum : max_q;
    idx_nxt = take ? cnt_q : idx_q;
    // len_q is never 0 in SEARCH, so the subtraction cannot underflow there.
    last    = (cnt_q == (len_q - WIN_W'(1)));
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      thr_q    <= '0;
      cnt_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      peak_val <= '0;
      peak_idx <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            len_q <= win_len;
            thr_q <= threshold;
            cnt_q <= '0;
            max_q <= '0;
            idx_q <= '0;
            if (win_len != '0) begin
              busy    <= 1'b1;
              state_q <= S_SEARCH;
            end else begin
              // An empty window reports immediately with a zero peak.
              done     <= 1'b1;
              peak_val <= '0;
              peak_idx <= '0;
              found    <= (threshold == '0);
              state_q  <= S_REPORT;
            end
          end
        end

        S_SEARCH: begin
          if (sum_vld) begin
            max_q <= max_nxt;
            idx_q <= idx_nxt;
            if (last) begin
              // Results are registered together with done, which gives a
              // one-cycle latency from the final sample.
              busy     <= 1'b0;
              done     <= 1'b1;
              peak_val <= max_nxt;
              peak_idx <= idx_nxt;
              found    <= (max_nxt >= thr_q);
              state_q  <= S_REPORT;
            end else begin
              cnt_q <= cnt_q + WIN_W'(1);
            end
          end
        end

        S_REPORT: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
